// File: rtl/cache_mem_arbiter_if.sv
// Bus bundle between the two cache controllers, the arbiter and main memory.
// The master side is the controller/memory environment; the slave side is the arbiter.
interface cache_mem_arbiter_if;
    logic        req0;
    logic        req1;
    logic        en0;
    logic        en1;
    logic        mwrite_en0;
    logic        mwrite_en1;
    logic [31:0] maddr0;
    logic [31:0] maddr1;
    logic [31:0] mdata0;
    logic [31:0] mdata1;
    logic [31:0] mout0;
    logic [31:0] mout1;
    logic        mwrite_en;
    logic [31:0] maddr;
    logic [31:0] mdata;
    logic [31:0] mout;
    logic        busy;
    logic        owner;
    logic [31:0] stall_cycles;
    logic        hold_err;

    modport master (
        output req0, req1, mwrite_en0, mwrite_en1,
        output maddr0, maddr1, mdata0, mdata1, mout,
        input  en0, en1, mout0, mout1, mwrite_en, maddr, mdata,
        input  busy, owner, stall_cycles, hold_err
    );

    modport slave (
        input  req0, req1, mwrite_en0, mwrite_en1,
        input  maddr0, maddr1, mdata0, mdata1, mout,
        output en0, en1, mout0, mout1, mwrite_en, maddr, mdata,
        output busy, owner, stall_cycles, hold_err
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Grants the single memory port to one cache controller for a whole miss
// sequence, stalling the other; tracks stall cycles and over-long grants.
module cache_mem_arbiter #(
    parameter int MAX_HOLD   = 64,
    parameter int HOLD_WIDTH = 16
) (
    input logic                clk,
    input logic                reset,
    cache_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT0 = 2'd1,
        S_GRANT1 = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_last;
    logic [HOLD_WIDTH-1:0] r_hold;
    logic [31:0]           r_stall;
    logic                  r_err;
    logic                  w_enter;
    logic                  w_granted;

    assign w_granted = (r_state != S_IDLE);
    assign w_enter   = (w_next != S_IDLE) && (w_next != r_state);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_last  <= 1'b1;
            r_hold  <= '0;
            r_stall <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_enter) begin
                r_last <= (w_next == S_GRANT1);
                r_hold <= '0;
            end else if (w_granted && (r_hold != '1)) begin
                r_hold <= r_hold + 1'b1;
            end
            if (w_granted && (r_hold >= HOLD_WIDTH'(MAX_HOLD))) begin
                r_err <= 1'b1;
            end
            if (!bus.en0 || !bus.en1) begin
                r_stall <= r_stall + 32'd1;
            end
        end
    end

    // A grant is never pre-empted; on release the waiting port takes over directly.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (bus.req0 && bus.req1) begin
                    w_next = r_last ? S_GRANT0 : S_GRANT1;
                end else if (bus.req0) begin
                    w_next = S_GRANT0;
                end else if (bus.req1) begin
                    w_next = S_GRANT1;
                end
            end
            S_GRANT0: begin
                if (!bus.req0) begin
                    w_next = bus.req1 ? S_GRANT1 : S_IDLE;
                end
            end
            S_GRANT1: begin
                if (!bus.req1) begin
                    w_next = bus.req0 ? S_GRANT0 : S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.en0          = !bus.req0 || (r_state == S_GRANT0);
        bus.en1          = !bus.req1 || (r_state == S_GRANT1);
        bus.mwrite_en    = 1'b0;
        bus.maddr        = '0;
        bus.mdata        = '0;
        bus.mout0        = '0;
        bus.mout1        = '0;
        bus.busy         = w_granted;
        bus.owner        = (r_state == S_GRANT1);
        bus.stall_cycles = r_stall;
        bus.hold_err     = r_err;
        unique case (r_state)
            S_GRANT0: begin
                bus.mwrite_en = bus.mwrite_en0;
                bus.maddr     = bus.maddr0;
                bus.mdata     = bus.mdata0;
                bus.mout0     = bus.mout;
            end
            S_GRANT1: begin
                bus.mwrite_en = bus.mwrite_en1;
                bus.maddr     = bus.maddr1;
                bus.mdata     = bus.mdata1;
                bus.mout1     = bus.mout;
            end
            default: ;
        endcase
    end
endmodule
